mmio_responder: RTL and testbench

- Memory-mapped I/O responder on the CPU memory bus; the other end of the CPU's mem_cmd/mem_addr/write-data interface for the upper address half (mem_addr[8]=1).
- The RAM serves mem_addr[8]=0. This block owns the LED, switch, timer and hex-display registers.
- The top level selects this block's read data when dout_en=1, otherwise the RAM's.

---
 rtl/mmio_responder_pkg.sv | 17 +
 rtl/hex_seg7.sv | 33 +++
 rtl/mmio_responder.sv | 137 +++++++++++++
 tb/tb_mmio_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_responder_pkg.sv
// Shared constants for the MMIO responder: bus command encodings and the
// register address map for the upper half of the 9-bit CPU address space.
package mmio_responder_pkg;

   // Bus commands. 2'b11 is not listed and is treated as no command.
   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   // Register addresses. All of them have bit 8 set.
   localparam logic [8:0] ADDR_LED   = 9'h100;
   localparam logic [8:0] ADDR_SW    = 9'h140;
   localparam logic [8:0] ADDR_TIMER = 9'h180;
   localparam logic [8:0] ADDR_TCTRL = 9'h181;
   localparam logic [8:0] ADDR_HEX   = 9'h1C0;

endpackage

// File: rtl/hex_seg7.sv
// Hex digit to 7-segment decoder, active-low segments.
// Ports:
//   nibble  in   4  hex digit 0..F
//   seg     out  7  segments {g,f,e,d,c,b,a}, 0 = lit
module hex_seg7 (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'b1111111;
      case (nibble)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped I/O responder for the upper address half (mem_addr[8]=1).
// Owns the LED, switch, timer and hex-display registers. Read data is
// registered to match the RAM's one-cycle read latency; dout_en tells the
// top level to select this block's data instead of the RAM's.
// Ports:
//   clk        in   1    system clock
//   reset      in   1    asynchronous active-low reset
//   mem_cmd    in   2    bus command (none / MREAD / MWRITE)
//   mem_addr   in   AW   bus address
//   din        in   DW   write data
//   sw         in   SWW  raw slide switches, asynchronous to clk
//   dout       out  DW   registered read data
//   dout_en    out  1    this block owns the read data
//   led        out  SWW  LED register
//   hex0..3    out  7    active-low segments for HEX_REG nibbles 0..3
//   timer_irq  out  1    sticky timer-wrap flag
module mmio_responder
   import mmio_responder_pkg::*;
#(
   parameter int unsigned DW  = 16,
   parameter int unsigned AW  = 9,
   parameter int unsigned SWW = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [1:0]     mem_cmd,
   input  logic [AW-1:0]  mem_addr,
   input  logic [DW-1:0]  din,
   input  logic [SWW-1:0] sw,
   output logic [DW-1:0]  dout,
   output logic           dout_en,
   output logic [SWW-1:0] led,
   output logic [6:0]     hex0,
   output logic [6:0]     hex1,
   output logic [6:0]     hex2,
   output logic [6:0]     hex3,
   output logic           timer_irq
);

   logic           sel;
   logic           wr_strobe;
   logic           wr_led, wr_timer, wr_tctrl, wr_hex;

   logic [SWW-1:0] led_q, led_d;
   logic [SWW-1:0] sw_meta_q, sw_sync_q;
   logic [DW-1:0]  timer_q, timer_d;
   logic           en_q, en_d;
   logic           wrap_q, wrap_d;
   logic [DW-1:0]  hex_q, hex_d;
   logic [DW-1:0]  dout_q, rdata;
   logic [DW:0]    timer_sum;
   logic           timer_wraps;

   assign sel       = mem_addr[AW-1];
   assign wr_strobe = sel && (mem_cmd == MWRITE);
   assign wr_led    = wr_strobe && (mem_addr == ADDR_LED);
   assign wr_timer  = wr_strobe && (mem_addr == ADDR_TIMER);
   assign wr_tctrl  = wr_strobe && (mem_addr == ADDR_TCTRL);
   assign wr_hex    = wr_strobe && (mem_addr == ADDR_HEX);

   assign dout_en = sel && (mem_cmd == MREAD);

   // Carry out of the increment marks the 0xFFFF -> 0x0000 wrap.
   assign timer_sum   = {1'b0, timer_q} + {{DW{1'b0}}, 1'b1};
   assign timer_wraps = en_q && timer_sum[DW] && !wr_timer;

   always_comb begin
      led_d   = led_q;
      hex_d   = hex_q;
      timer_d = timer_q;
      en_d    = en_q;
      wrap_d  = wrap_q;

      if (wr_led) led_d = din[SWW-1:0];
      if (wr_hex) hex_d = din;

      // A bus write to TIMER overrides the increment in the same cycle.
      if (wr_timer) begin
         timer_d = din;
      end else if (en_q) begin
         timer_d = timer_sum[DW-1:0];
      end

      // The new enable only affects the next cycle's increment.
      if (wr_tctrl) begin
         en_d = din[0];
         if (din[1]) wrap_d = 1'b0;
      end
      // Set has priority over a concurrent clear.
      if (timer_wraps) wrap_d = 1'b1;
   end

   // Read mux; full decode, unmapped addresses read as zero.
   always_comb begin
      rdata = '0;
      case (mem_addr)
         ADDR_LED:   rdata = {{(DW-SWW){1'b0}}, led_q};
         ADDR_SW:    rdata = {{(DW-SWW){1'b0}}, sw_sync_q};
         ADDR_TIMER: rdata = timer_q;
         ADDR_TCTRL: rdata = {{(DW-2){1'b0}}, wrap_q, en_q};
         ADDR_HEX:   rdata = hex_q;
         default:    rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_q     <= '0;
         hex_q     <= '0;
         timer_q   <= '0;
         en_q      <= 1'b0;
         wrap_q    <= 1'b0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
         dout_q    <= '0;
      end else begin
         led_q     <= led_d;
         hex_q     <= hex_d;
         timer_q   <= timer_d;
         en_q      <= en_d;
         wrap_q    <= wrap_d;
         sw_meta_q <= sw;
         sw_sync_q <= sw_meta_q;
         dout_q    <= rdata;
      end
   end

   assign dout      = dout_q;
   assign led       = led_q;
   assign timer_irq = wrap_q;

   hex_seg7 u_hex0 (.nibble(hex_q[3:0]),   .seg(hex0));
   hex_seg7 u_hex1 (.nibble(hex_q[7:4]),   .seg(hex1));
   hex_seg7 u_hex2 (.nibble(hex_q[11:8]),  .seg(hex2));
   hex_seg7 u_hex3 (.nibble(hex_q[15:12]), .seg(hex3));

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed scenarios with literal expectations plus
// randomized bus traffic, all checked every cycle against a register-level
// model of the memory map.
module tb_mmio_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  mem_cmd = 2'b00;
   logic [8:0]  mem_addr = 9'h000;
   logic [15:0] din = 16'h0000;
   logic [7:0]  sw = 8'h00;
   logic [15:0] dout;
   logic        dout_en;
   logic [7:0]  led;
   logic [6:0]  hex0, hex1, hex2, hex3;
   logic        timer_irq;

   int total = 0;
   int bad = 0;

   // Model state: plain register values from the memory map.
   logic [7:0]  m_led;
   logic [15:0] m_hex;
   int unsigned m_timer;
   bit          m_en, m_wrap;
   logic [7:0]  m_sw_pipe [2];
   logic [15:0] m_dout;

   mmio_responder dut (
      .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .din(din),
      .sw(sw), .dout(dout), .dout_en(dout_en), .led(led), .hex0(hex0), .hex1(hex1),
      .hex2(hex2), .hex3(hex3), .timer_irq(timer_irq)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg(input logic [3:0] n);
      logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return tbl[n];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_led = 0; m_hex = 0; m_timer = 0; m_en = 0; m_wrap = 0;
      m_sw_pipe[0] = 0; m_sw_pipe[1] = 0; m_dout = 0;
   endtask

   function automatic logic [15:0] model_read(input logic [8:0] a);
      case (a)
         9'h100: return {8'h00, m_led};
         9'h140: return {8'h00, m_sw_pipe[1]};
         9'h180: return m_timer[15:0];
         9'h181: return {14'b0, m_wrap, m_en};
         9'h1C0: return m_hex;
         default: return 16'h0000;
      endcase
   endfunction

   // Apply one clock edge to the model using the currently driven inputs.
   task automatic model_edge();
      bit wr, count_wrap;
      bit new_en;
      int unsigned next_t;
      if (!reset) begin
         model_reset();
         return;
      end
      m_dout = model_read(mem_addr);
      wr = mem_addr[8] && mem_cmd == 2'b10;
      new_en = m_en;
      count_wrap = 0;
      next_t = m_timer;
      if (m_en) begin
         next_t = (m_timer + 1) % 65536;
         count_wrap = (m_timer == 65535);
      end
      if (wr && mem_addr == 9'h180) begin
         next_t = din;
         count_wrap = 0;
      end
      if (wr && mem_addr == 9'h181) begin
         new_en = din[0];
         if (din[1]) m_wrap = 0;
      end
      if (count_wrap) m_wrap = 1;
      m_timer = next_t;
      m_en = new_en;
      if (wr && mem_addr == 9'h100) m_led = din[7:0];
      if (wr && mem_addr == 9'h1C0) m_hex = din;
      m_sw_pipe[1] = m_sw_pipe[0];
      m_sw_pipe[0] = sw;
   endtask

   task automatic compare();
      chk("led", led, m_led);
      chk("hex0", hex0, seg(m_hex[3:0]));
      chk("hex1", hex1, seg(m_hex[7:4]));
      chk("hex2", hex2, seg(m_hex[11:8]));
      chk("hex3", hex3, seg(m_hex[15:12]));
      chk("timer_irq", timer_irq, m_wrap);
      chk("dout", dout, m_dout);
      chk("dout_en", dout_en, mem_addr[8] && mem_cmd == 2'b01);
   endtask

   // Drive inputs, take one edge, update model, check 1 time unit later.
   task automatic step(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
      mem_cmd = c; mem_addr = a; din = d;
      #0;
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(2'b00, 9'h000, 16'h0000);
   endtask

   initial begin
      model_reset();
      idle(2);
      reset = 1'b1;
      idle(2);

      // Mid-run asynchronous reset after some state is loaded.
      step(2'b10, 9'h100, 16'h00A5);
      step(2'b10, 9'h1C0, 16'h9876);
      step(2'b01, 9'h100, 16'h0000);
      reset = 1'b0;
      #2;
      model_reset();
      chk("rst_led", led, 8'h00);
      chk("rst_dout", dout, 16'h0000);
      chk("rst_hex0", hex0, 7'b1000000);
      chk("rst_hex3", hex3, 7'b1000000);
      chk("rst_irq", timer_irq, 1'b0);
      idle(1);
      reset = 1'b1;
      idle(1);

      // LED register.
      step(2'b10, 9'h100, 16'hBEEF);
      chk("led_lit", led, 8'hEF);
      step(2'b01, 9'h100, 16'h0000);
      step(2'b01, 9'h100, 16'h0000);
      chk("led_rd", dout, 16'h00EF);
      chk("led_rd_en", dout_en, 1'b1);
      step(2'b01, 9'h0A0, 16'h0000);
      chk("ram_en", dout_en, 1'b0);

      // Switch synchronizer and read-only SW_REG.
      sw = 8'h5A;
      idle(3);
      step(2'b01, 9'h140, 16'h0000);
      step(2'b01, 9'h140, 16'h0000);
      chk("sw_rd", dout, 16'h005A);
      step(2'b10, 9'h140, 16'hFFFF);
      chk("sw_wr_led", led, 8'hEF);

      // Timer wrap then clear/disable.
      step(2'b10, 9'h180, 16'hFFFE);
      step(2'b10, 9'h181, 16'h0001);
      idle(2);
      chk("wrap_irq", timer_irq, 1'b1);
      step(2'b10, 9'h181, 16'h0002);
      chk("clr_irq", timer_irq, 1'b0);
      step(2'b01, 9'h180, 16'h0000);
      step(2'b01, 9'h180, 16'h0000);
      chk("timer_hold", dout, 16'h0001);

      // Write beats a wrapping increment.
      step(2'b10, 9'h180, 16'hFFFF);
      step(2'b10, 9'h181, 16'h0001);
      step(2'b10, 9'h180, 16'h0010);
      chk("wr_wins_irq", timer_irq, 1'b0);
      step(2'b01, 9'h180, 16'h0000);
      chk("wr_wins_val", dout, 16'h0010);

      // Wrap beats a concurrent clear.
      step(2'b10, 9'h180, 16'hFFFF);
      step(2'b10, 9'h181, 16'h0003);
      chk("set_wins", timer_irq, 1'b1);
      step(2'b01, 9'h181, 16'h0000);
      chk("tctrl_rd", dout, 16'h0003);
      step(2'b10, 9'h181, 16'h0002);

      // Hex display.
      step(2'b10, 9'h1C0, 16'h12AF);
      chk("hex0_lit", hex0, 7'b0001110);
      chk("hex1_lit", hex1, 7'b0001000);
      chk("hex2_lit", hex2, 7'b0100100);
      chk("hex3_lit", hex3, 7'b1111001);
      step(2'b01, 9'h1C0, 16'h0000);
      chk("hex_rd", dout, 16'h12AF);
      step(2'b01, 9'h1FF, 16'h0000);
      chk("unmapped_rd", dout, 16'h0000);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         logic [8:0]  a;
         logic [1:0]  c;
         logic [15:0] d;
         case ($urandom_range(0, 6))
            0: a = 9'h100;
            1: a = 9'h140;
            2, 3: a = 9'h180;
            4: a = 9'h181;
            5: a = 9'h1C0;
            default: a = 9'($urandom);
         endcase
         c = 2'($urandom);
         d = 16'($urandom);
         if (a == 9'h180 && $urandom_range(0, 1) == 1) d = 16'hFFF0 | 16'($urandom_range(0, 15));
         if (a == 9'h181 && $urandom_range(0, 2) != 0) d[0] = 1'b1;
         if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
         step(c, a, d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
